// File: rtl/nand_cpu_pkg.sv
// Shared types and constants for nand_cpu and its boot-time program loader.
package nand_cpu_pkg;

  // Loader command bytes (ASCII 'I', 'D', 'G')
  localparam logic [7:0] CMD_I  = 8'h49;
  localparam logic [7:0] CMD_D  = 8'h44;
  localparam logic [7:0] CMD_GO = 8'h47;

  // Loader sequencing states
  typedef enum logic [3:0] {
    LD_CMD     = 4'd0,
    LD_LEN_LO  = 4'd1,
    LD_LEN_HI  = 4'd2,
    LD_ADDR_LO = 4'd3,
    LD_ADDR_HI = 4'd4,
    LD_DATA    = 4'd5,
    LD_CKSUM   = 4'd6,
    LD_RUN     = 4'd7,
    LD_HALTED  = 4'd8,
    LD_ERR     = 4'd9
  } loader_state_e;

  // Target memory of the byte-wide write port
  typedef enum logic {
    SEL_IMEM = 1'b0,
    SEL_DMEM = 1'b1
  } mem_sel_e;

  // True in every state that consumes bytes from the input stream
  function automatic logic loader_accepts(input loader_state_e s);
    case (s)
      LD_CMD, LD_LEN_LO, LD_LEN_HI, LD_ADDR_LO,
      LD_ADDR_HI, LD_DATA, LD_CKSUM: loader_accepts = 1'b1;
      default:                       loader_accepts = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Boot-time program loader: decodes a byte stream into I_MEM/D_MEM writes,
// holds nand_cpu in reset until GO, then tracks run/halt.
// Optional build macro PROG_LOADER_CKSUM_EN appends a per-command
// modulo-256 checksum byte after each load payload.
module prog_loader #(
  parameter int unsigned ADDR_W = 16,
  parameter logic [7:0]  CMD_I  = nand_cpu_pkg::CMD_I,
  parameter logic [7:0]  CMD_D  = nand_cpu_pkg::CMD_D,
  parameter logic [7:0]  CMD_GO = nand_cpu_pkg::CMD_GO
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_n_rst,
  input  logic              cpu_halt,
  output logic              running,
  output logic              halted,
  output logic              err
);
  import nand_cpu_pkg::*;

  localparam int unsigned LEN_W = 16;

  loader_state_e     state_q,     state_d;
  mem_sel_e          sel_q,       sel_d;
  logic [LEN_W-1:0]  len_q,       len_d;
  logic [7:0]        addr_lo_q,   addr_lo_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic              in_ready_q,  in_ready_d;
  logic              mem_we_q,    mem_we_d;
  mem_sel_e          mem_sel_q,   mem_sel_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              cpu_n_rst_q, cpu_n_rst_d;
  logic              running_q,   running_d;
  logic              halted_q,    halted_d;
  logic              err_q,       err_d;
`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]        cksum_q,     cksum_d;
`endif

  logic accept;
  assign accept = in_valid & in_ready_q;

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    len_d       = len_q;
    addr_lo_d   = addr_lo_q;
    addr_d      = addr_q;
    mem_we_d    = 1'b0;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_n_rst_d = cpu_n_rst_q;
    running_d   = running_q;
    halted_d    = halted_q;
    err_d       = err_q;
`ifdef PROG_LOADER_CKSUM_EN
    cksum_d     = cksum_q;
`endif

    case (state_q)
      LD_CMD: begin
        if (accept) begin
          if (in_data == CMD_I || in_data == CMD_D) begin
            sel_d   = (in_data == CMD_D) ? SEL_DMEM : SEL_IMEM;
            state_d = LD_LEN_LO;
`ifdef PROG_LOADER_CKSUM_EN
            cksum_d = 8'h00;
`endif
          end else if (in_data == CMD_GO) begin
            state_d     = LD_RUN;
            cpu_n_rst_d = 1'b1;
            running_d   = 1'b1;
          end else begin
            state_d = LD_ERR;
            err_d   = 1'b1;
          end
        end
      end

      LD_LEN_LO: begin
        if (accept) begin
          len_d   = {len_q[15:8], in_data};
          state_d = LD_LEN_HI;
        end
      end

      LD_LEN_HI: begin
        if (accept) begin
          len_d   = {in_data, len_q[7:0]};
          state_d = LD_ADDR_LO;
        end
      end

      LD_ADDR_LO: begin
        if (accept) begin
          addr_lo_d = in_data;
          state_d   = LD_ADDR_HI;
        end
      end

      LD_ADDR_HI: begin
        if (accept) begin
          addr_d = ADDR_W'({in_data, addr_lo_q});
          if (len_q == LEN_W'(0)) begin
`ifdef PROG_LOADER_CKSUM_EN
            state_d = LD_CKSUM;
`else
            state_d = LD_CMD;
`endif
          end else begin
            state_d = LD_DATA;
          end
        end
      end

      LD_DATA: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_sel_d   = sel_q;
          mem_addr_d  = addr_q;
          mem_wdata_d = in_data;
          addr_d      = addr_q + ADDR_W'(1);
          len_d       = len_q - LEN_W'(1);
`ifdef PROG_LOADER_CKSUM_EN
          cksum_d     = cksum_q + in_data;
`endif
          if (len_q == LEN_W'(1)) begin
`ifdef PROG_LOADER_CKSUM_EN
            state_d = LD_CKSUM;
`else
            state_d = LD_CMD;
`endif
          end
        end
      end

`ifdef PROG_LOADER_CKSUM_EN
      LD_CKSUM: begin
        if (accept) begin
          if (in_data == cksum_q) begin
            state_d = LD_CMD;
          end else begin
            state_d = LD_ERR;
            err_d   = 1'b1;
          end
        end
      end
`endif

      LD_RUN: begin
        if (cpu_halt) begin
          state_d   = LD_HALTED;
          halted_d  = 1'b1;
          running_d = 1'b0;
        end
      end

      default: begin
      end
    endcase

    in_ready_d = loader_accepts(state_d);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= LD_CMD;
      sel_q       <= SEL_IMEM;
      len_q       <= '0;
      addr_lo_q   <= '0;
      addr_q      <= '0;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= SEL_IMEM;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_n_rst_q <= 1'b0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
      cksum_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      len_q       <= len_d;
      addr_lo_q   <= addr_lo_d;
      addr_q      <= addr_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_n_rst_q <= cpu_n_rst_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
`ifdef PROG_LOADER_CKSUM_EN
      cksum_q     <= cksum_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_n_rst = cpu_n_rst_q;
  assign running   = running_q;
  assign halted    = halted_q;
  assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of per-cycle vectors plus
// hand-written gap and checksum sequences.
module tb_prog_loader;

  logic        clk;
  logic        n_rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic        mem_sel;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_n_rst;
  logic        cpu_halt;
  logic        running;
  logic        halted;
  logic        err;

  int checks;
  int failures;

  prog_loader dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_n_rst (cpu_n_rst),
    .cpu_halt  (cpu_halt),
    .running   (running),
    .halted    (halted),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag vector order: {in_ready, mem_we, mem_sel, cpu_n_rst, running, halted, err}
  localparam logic [6:0] F_RDY   = 7'b1000000;
  localparam logic [6:0] F_WR_I  = 7'b1100000;
  localparam logic [6:0] F_WR_D  = 7'b1110000;
  localparam logic [6:0] F_HOLDD = 7'b1010000;
  localparam logic [6:0] F_RUN   = 7'b0001100;
  localparam logic [6:0] F_HALT  = 7'b0001010;
  localparam logic [6:0] F_ERR   = 7'b0000001;

  // Each row: expected outputs at this negedge, then inputs to drive
  typedef struct {
    logic        rst_n;
    logic        v;
    logic [7:0]  d;
    logic        halt;
    logic [6:0]  flags;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic rst_n, input logic v, input logic [7:0] d,
                     input logic halt, input logic [6:0] flags,
                     input logic [15:0] addr, input logic [7:0] wdata);
    vec_t r;
    r.rst_n = rst_n; r.v = v; r.d = d; r.halt = halt;
    r.flags = flags; r.addr = addr; r.wdata = wdata;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] flags_now();
    return {in_ready, mem_we, mem_sel, cpu_n_rst, running, halted, err};
  endfunction

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    n_rst    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    cpu_halt = 1'b0;

    // D_MEM load of four bytes at 0..3
    row(1, 1, 8'h44, 0, F_RDY, 16'h0000, 8'h00);
    row(1, 1, 8'h04, 0, F_RDY, 16'h0000, 8'h00);
    row(1, 1, 8'h00, 0, F_RDY, 16'h0000, 8'h00);
    row(1, 1, 8'h00, 0, F_RDY, 16'h0000, 8'h00);
    row(1, 1, 8'h00, 0, F_RDY, 16'h0000, 8'h00);
    row(1, 1, 8'h11, 0, F_RDY, 16'h0000, 8'h00);
    row(1, 1, 8'h22, 0, F_WR_D, 16'h0000, 8'h11);
    row(1, 1, 8'h33, 0, F_WR_D, 16'h0001, 8'h22);
    row(1, 1, 8'h44, 0, F_WR_D, 16'h0002, 8'h33);
`ifdef PROG_LOADER_CKSUM_EN
    row(1, 1, 8'hAA, 0, F_WR_D, 16'h0003, 8'h44);
    row(1, 1, 8'h49, 0, F_HOLDD, 16'h0003, 8'h44);
`else
    row(1, 1, 8'h49, 0, F_WR_D, 16'h0003, 8'h44);
`endif
    // I_MEM load of two bytes wrapping from FFFF to 0000
    row(1, 1, 8'h02, 0, F_HOLDD, 16'h0003, 8'h44);
    row(1, 1, 8'h00, 0, F_HOLDD, 16'h0003, 8'h44);
    row(1, 1, 8'hFF, 0, F_HOLDD, 16'h0003, 8'h44);
    row(1, 1, 8'hFF, 0, F_HOLDD, 16'h0003, 8'h44);
    row(1, 1, 8'hAA, 0, F_HOLDD, 16'h0003, 8'h44);
    row(1, 1, 8'hBB, 0, F_WR_I, 16'hFFFF, 8'hAA);
`ifdef PROG_LOADER_CKSUM_EN
    row(1, 1, 8'h65, 0, F_WR_I, 16'h0000, 8'hBB);
    row(1, 1, 8'h47, 0, F_RDY, 16'h0000, 8'hBB);
`else
    row(1, 1, 8'h47, 0, F_WR_I, 16'h0000, 8'hBB);
`endif
    // GO, run, halt; bytes after halt are ignored
    row(1, 0, 8'h00, 0, F_RUN, 16'h0000, 8'hBB);
    row(1, 0, 8'h00, 1, F_RUN, 16'h0000, 8'hBB);
    row(1, 1, 8'h44, 0, F_HALT, 16'h0000, 8'hBB);
    row(1, 0, 8'h00, 0, F_HALT, 16'h0000, 8'hBB);
    row(0, 0, 8'h00, 0, F_HALT, 16'h0000, 8'hBB);
    // Unknown command -> sticky error; GO ignored
    row(1, 1, 8'h5A, 0, F_RDY, 16'h0000, 8'h00);
    row(1, 1, 8'h47, 0, F_ERR, 16'h0000, 8'h00);
    row(1, 0, 8'h00, 0, F_ERR, 16'h0000, 8'h00);
    row(0, 0, 8'h00, 0, F_ERR, 16'h0000, 8'h00);
    // Reset after two of four data bytes abandons the load
    row(1, 1, 8'h44, 0, F_RDY, 16'h0000, 8'h00);
    row(1, 1, 8'h04, 0, F_RDY, 16'h0000, 8'h00);
    row(1, 1, 8'h00, 0, F_RDY, 16'h0000, 8'h00);
    row(1, 1, 8'h00, 0, F_RDY, 16'h0000, 8'h00);
    row(1, 1, 8'h00, 0, F_RDY, 16'h0000, 8'h00);
    row(1, 1, 8'h11, 0, F_RDY, 16'h0000, 8'h00);
    row(1, 1, 8'h22, 0, F_WR_D, 16'h0000, 8'h11);
    row(0, 1, 8'h33, 0, F_WR_D, 16'h0001, 8'h22);
    row(0, 1, 8'h44, 0, F_RDY, 16'h0000, 8'h00);
    row(1, 1, 8'h47, 0, F_RDY, 16'h0000, 8'h00);
    row(1, 0, 8'h00, 0, F_RUN, 16'h0000, 8'h00);
    row(1, 0, 8'h00, 0, F_RUN, 16'h0000, 8'h00);
    row(0, 0, 8'h00, 0, F_RUN, 16'h0000, 8'h00);
    row(1, 0, 8'h00, 0, F_RDY, 16'h0000, 8'h00);

    // Reset held for two cycles
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d_flags", i), 32'(flags_now()), 32'(vecs[i].flags));
      chk($sformatf("vec%0d_addr_data", i), {8'h00, mem_addr, mem_wdata},
          {8'h00, vecs[i].addr, vecs[i].wdata});
      n_rst    = vecs[i].rst_n;
      in_valid = vecs[i].v;
      in_data  = vecs[i].d;
      cpu_halt = vecs[i].halt;
    end

    // Load of one byte at 0x0010 with gaps in in_valid
    send(8'h49); idle();
    send(8'h01); idle(); idle();
    send(8'h00);
    send(8'h10); idle();
    send(8'h00); idle();
    chk("gap_no_early_write", 32'(mem_we), 32'd0);
    send(8'h5C);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 4 && !seen; k++) begin
        @(negedge clk);
        in_valid = 1'b0;
        if (mem_we) seen = 1'b1;
      end
      chk("gap_write_seen", 32'(seen), 32'd1);
      chk("gap_write_port", {7'd0, mem_sel, mem_addr, mem_wdata}, {7'd0, 1'b0, 16'h0010, 8'h5C});
      @(negedge clk);
      chk("gap_single_pulse", 32'(mem_we), 32'd0);
    end
`ifdef PROG_LOADER_CKSUM_EN
    send(8'h5C); idle();
    chk("gap_cksum_ok", 32'({in_ready, err}), 32'b10);

    // Correct checksum returns to CMD
    send(8'h44); send(8'h02); send(8'h00); send(8'h00); send(8'h00);
    send(8'h10); send(8'h20); send(8'h30); idle();
    chk("cksum_match", 32'({in_ready, err}), 32'b10);
    // Wrong checksum flags an error after writes were issued
    send(8'h44); send(8'h02); send(8'h00); send(8'h00); send(8'h00);
    send(8'h10); send(8'h20); send(8'h31); idle();
    chk("cksum_mismatch", 32'({in_ready, err, cpu_n_rst}), 32'b010);
`else
    idle();
    chk("gap_back_in_cmd", 32'({in_ready, err, running}), 32'b100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
